// File: rtl/ysyx_220066_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package : ysyx_220066_mem_pkg
// Desc    : Shared constants for the MEM stage: load/store access types
//           (funct3 encoding), access-size byte masks and FSM state encoding.
// Rev     : 1.0 - initial release
// ============================================================================
package ysyx_220066_mem_pkg;

  // Access type, funct3 encoding
  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LD  = 3'b011;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;
  localparam logic [2:0] MEMOP_LWU = 3'b110;
  localparam logic [2:0] MEMOP_ILL = 3'b111;

  // Access size taken from MemOp[1:0]
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // Byte-strobe patterns for an access at offset 0
  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } mem_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return MASK_B;
      SIZE_H:  return MASK_H;
      SIZE_W:  return MASK_W;
      SIZE_D:  return MASK_D;
      default: return MASK_D;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_220066_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Interface : ysyx_220066_mem_stage_if
// Desc      : Data-memory req/ack port. The MEM stage is the master; the
//             memory (or its bus adapter) is the slave.
// Rev       : 1.0 - initial release
// ============================================================================
interface ysyx_220066_mem_stage_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        ack;
  logic [63:0] rdata;

  modport master (output req, we, addr, wdata, wmask, input ack, rdata);
  modport slave  (input req, we, addr, wdata, wmask, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/ysyx_220066_mem_stage_lsu_align.sv
`default_nettype none
// ============================================================================
// Module : ysyx_220066_lsu_align
// Desc   : Combinational load/store alignment: misaligned/illegal check,
//          store lane shift and byte strobes, load shift and extension.
// Rev    : 1.0 - initial release
// ============================================================================
module ysyx_220066_lsu_align
  import ysyx_220066_mem_pkg::*;
(
  input  logic [2:0]  memop,
  input  logic        is_store,
  input  logic [2:0]  off,
  input  logic [63:0] store_data,
  input  logic [63:0] load_src,
  output logic        bad,
  output logic [63:0] wdata,
  output logic [7:0]  wmask,
  output logic [63:0] load_data
);

  logic [5:0]  sh_amt;
  logic [63:0] raw;
  logic        misaligned;
  logic        illegal;

  assign sh_amt = {off, 3'b000};

  // Stores: shift data into its byte lanes; strobes follow the access size
  assign wdata = store_data << sh_amt;
  assign wmask = size_mask(memop[1:0]) << off;

  // Loads: bring the addressed bytes down to bit 0
  assign raw = load_src >> sh_amt;

  // An access must be naturally aligned to its size
  always_comb begin
    misaligned = 1'b0;
    case (memop[1:0])
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = off[0];
      SIZE_W:  misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  end

  // Stores have no unsigned variants, so any MemOp[2]=1 store is illegal
  assign illegal = is_store ? memop[2] : (memop == MEMOP_ILL);
  assign bad     = misaligned | illegal;

  // Sign- or zero-extend the shifted load data to 64 bits
  always_comb begin
    load_data = raw;
    case (memop)
      MEMOP_LB:  load_data = {{56{raw[7]}},  raw[7:0]};
      MEMOP_LH:  load_data = {{48{raw[15]}}, raw[15:0]};
      MEMOP_LW:  load_data = {{32{raw[31]}}, raw[31:0]};
      MEMOP_LD:  load_data = raw;
      MEMOP_LBU: load_data = {56'd0, raw[7:0]};
      MEMOP_LHU: load_data = {48'd0, raw[15:0]};
      MEMOP_LWU: load_data = {32'd0, raw[31:0]};
      default:   load_data = raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_220066_mem_stage.sv
`default_nettype none
// ============================================================================
// Module : ysyx_220066_mem_stage
// Desc   : MEM stage of the ysyx_220066 RV64 pipeline. Latches EX results,
//          runs loads/stores over a req/ack data-memory port and raises busy
//          while an access is outstanding.
//          Optional ack watchdog: define YSYX_220066_MEM_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module ysyx_220066_mem_stage
  import ysyx_220066_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        block,
  input  logic        valid_in,
  input  logic        error_in,
  input  logic        done_in,
  input  logic [63:0] result_in,
  input  logic [63:0] store_data_in,
  input  logic [63:0] pc_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  MemOp_in,
  input  logic        MemRd_in,
  input  logic        MemWr_in,
  input  logic        RegWr_in,
  ysyx_220066_mem_stage_if.master dmem,
  output logic        valid,
  output logic        error,
  output logic        busy,
  output logic [63:0] wb_data,
  output logic [63:0] pc,
  output logic [4:0]  rd,
  output logic        RegWr,
  output logic        MemRd,
  output logic        done
);

  // Stage register
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        done_q, done_d;
  logic [63:0] result_q, result_d;
  logic [63:0] store_data_q, store_data_d;
  logic [63:0] pc_q, pc_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  memop_q, memop_d;
  logic        memrd_q, memrd_d;
  logic        memwr_q, memwr_d;
  logic        regwr_q, regwr_d;

  // Access control
  mem_state_e  state_q, state_d;
  logic [63:0] rdata_q, rdata_d;

  logic        cap;
  logic        is_mem;
  logic        align_bad;
  logic        bad;
  logic        pending;
  logic        req;
  logic        tmo_flag;
  logic        tmo_fire;
  logic [63:0] load_src;
  logic [63:0] load_data;
  logic [63:0] wdata;
  logic [7:0]  wmask;

  assign is_mem   = memrd_q | memwr_q;
  assign load_src = (state_q == ST_HOLD) ? rdata_q : dmem.rdata;

  ysyx_220066_lsu_align u_align (
    .memop      (memop_q),
    .is_store   (memwr_q),
    .off        (result_q[2:0]),
    .store_data (store_data_q),
    .load_src   (load_src),
    .bad        (align_bad),
    .wdata      (wdata),
    .wmask      (wmask),
    .load_data  (load_data)
  );

  // Only a real memory instruction can be misaligned or illegal
  assign bad     = valid_q & is_mem & align_bad;
  assign pending = valid_q & is_mem & ~error_q & ~align_bad & ~tmo_flag;
  // Request is combinational so a zero-wait memory can ack in the same cycle;
  // HOLD suppresses it so a completed access is not replayed while stalled
  assign req     = pending & (state_q != ST_HOLD);
  assign busy    = req & ~dmem.ack;
  assign cap     = ~block & ~busy;

  // Next stage-register contents: load from EX on capture, otherwise hold
  always_comb begin
    valid_d      = valid_q;
    error_d      = error_q;
    done_d       = done_q;
    result_d     = result_q;
    store_data_d = store_data_q;
    pc_d         = pc_q;
    rd_d         = rd_q;
    memop_d      = memop_q;
    memrd_d      = memrd_q;
    memwr_d      = memwr_q;
    regwr_d      = regwr_q;
    if (cap) begin
      valid_d      = valid_in;
      error_d      = error_in;
      done_d       = done_in;
      result_d     = result_in;
      store_data_d = store_data_in;
      pc_d         = pc_in;
      rd_d         = rd_in;
      memop_d      = MemOp_in;
      memrd_d      = MemRd_in;
      memwr_d      = MemWr_in;
      regwr_d      = RegWr_in;
    end
  end

  // Stage register flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= 64'd0;
      store_data_q <= 64'd0;
      pc_q         <= 64'd0;
      rd_q         <= 5'd0;
      memop_q      <= 3'd0;
      memrd_q      <= 1'b0;
      memwr_q      <= 1'b0;
      regwr_q      <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      error_q      <= error_d;
      done_q       <= done_d;
      result_q     <= result_d;
      store_data_q <= store_data_d;
      pc_q         <= pc_d;
      rd_q         <= rd_d;
      memop_q      <= memop_d;
      memrd_q      <= memrd_d;
      memwr_q      <= memwr_d;
      regwr_q      <= regwr_d;
    end
  end

  // Access FSM next state; read data is latched whenever the ack lands
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (dmem.ack) begin
            rdata_d = dmem.rdata;
            state_d = block ? ST_HOLD : ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (req && dmem.ack) begin
          rdata_d = dmem.rdata;
          state_d = block ? ST_HOLD : ST_IDLE;
        end else if (tmo_fire) begin
          state_d = block ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!block) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Access FSM flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef YSYX_220066_MEM_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;

  assign tmo_fire = (state_q == ST_WAIT) & req & ~dmem.ack & (cnt_q == CNT_LAST);
  // A timed-out access stays flagged (and un-requested) until the next capture
  assign tmo_flag = tmo_q;

  // Watchdog: count WAIT cycles from zero, flag the instruction on expiry
  always_comb begin
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    if (state_q == ST_IDLE && req && !dmem.ack) begin
      cnt_d = 16'd0;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (cap) begin
      tmo_d = 1'b0;
    end else if (tmo_fire) begin
      tmo_d = 1'b1;
    end
  end

  // Watchdog flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign tmo_fire           = 1'b0;
  assign tmo_flag           = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Memory port
  assign dmem.req   = req;
  assign dmem.we    = memwr_q;
  assign dmem.addr  = {result_q[63:3], 3'b000};
  assign dmem.wdata = wdata;
  assign dmem.wmask = wmask;

  // Write-back side: bubbles go to WB while the access is outstanding
  assign valid   = valid_q & ~busy;
  assign error   = error_q | bad | tmo_flag;
  assign wb_data = memrd_q ? load_data : result_q;
  assign pc      = pc_q;
  assign rd      = rd_q;
  assign RegWr   = regwr_q;
  assign MemRd   = memrd_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: doc/ysyx_220066_mem_stage.md
Name: ysyx_220066_mem_stage

Overview:
- Memory-access stage of the ysyx_220066 5-stage RV64 pipeline, directly downstream of EX.
- Latches the EX outputs into its stage register and performs loads/stores over a req/ack data-memory port that may take several cycles.
- Aligns store data, extends load data and forwards write-back data to WB.
- Asserts busy while an access is outstanding so the hazard unit stalls the pipeline.

Parameters:
- TIMEOUT_CYCLES, 255: ack watchdog limit in cycles; used only when YSYX_220066_MEM_TIMEOUT_EN is defined.

Ports:
- clk in 1: clock.
- rst in 1: asynchronous, active-high reset.
- block in 1: downstream/hazard stall; the stage register holds while block=1.
- valid_in, error_in, done_in in 1 each: from EX.
- result_in in 64: ALU result; this is the effective address for memory operations.
- store_data_in in 64: forwarded rs2 value.
- pc_in in 64: instruction PC.
- rd_in in 5: destination register.
- MemOp_in in 3: access type (funct3 encoding).
- MemRd_in, MemWr_in, RegWr_in in 1 each: control bits.
- dmem_req out 1: memory request.
- dmem_we out 1: write enable.
- dmem_addr out 64: {addr[63:3],3'b000}.
- dmem_wdata out 64: lane-shifted store data.
- dmem_wmask out 8: byte strobes.
- dmem_ack in 1: access complete.
- dmem_rdata in 64: read data for the aligned doubleword.
- valid out 1: WB may consume this cycle.
- error out 1: error_q OR misaligned/illegal OR timeout.
- busy out 1: stall request to the hazard unit.
- wb_data out 64: value written back to rd.
- pc out 64, rd out 5, RegWr out 1, MemRd out 1, done out 1: passthrough to WB and forwarding logic.

Behaviour:
- Stage register:
  - Captures all *_in inputs on posedge when cap = ~block & ~busy.
  - Async reset clears every register to 0 and sets state to IDLE.
  - Consequence: at reset valid=0, dmem_req=0, busy=0, error=0, wb_data=0.
- Address offset: off = result_q[2:0].
- MemOp encoding: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
  - 111 is illegal; for stores only 000–011 are legal.
- Misaligned:
  - h: off[0]≠0; w: off[1:0]≠0; d: off≠0.
  - Misaligned or illegal access → bad=1.
- pending = valid_q & (MemRd_q|MemWr_q) & ~error_q & ~bad.
- Request: dmem_req = pending & (state≠HOLD). It is combinational, so a zero-wait memory may ack in the same cycle.
  - addr, we, wdata and wmask stay stable until ack.
- Store formatting:
  - wdata = store_data_q << (8·off).
  - wmask = {1,3,15,255}[size] << off.
- Load formatting:
  - raw = src >> (8·off), where src = (state==HOLD) ? rdata_q : dmem_rdata.
  - Sign-extend or zero-extend raw to 64 bits per MemOp.
  - wb_data = MemRd_q ? formatted load : result_q.
- busy = dmem_req & ~dmem_ack.
- valid = valid_q & ~busy. Bubbles are presented to WB while waiting.
- FSM transitions:
  - IDLE: dmem_req & ~ack → WAIT. ack & block → HOLD, latch rdata_q. ack & ~block → IDLE (next instruction captured at the same edge).
  - WAIT: ack → HOLD if block, otherwise IDLE (latch rdata_q). No ack → stay in WAIT.
  - HOLD: no request is issued. ~block → IDLE. Prevents re-issuing the access while stalled.
- Errors:
  - error=1 → no request is issued.
  - valid follows valid_q and RegWr passes through; WB suppresses the write on error.
- Stray ack: dmem_ack while dmem_req=0 is ignored.
- Reset mid-access: dmem_req drops immediately; a later ack is ignored.
- Stores: wb_data = result_q; RegWr passes through as captured.

Optional Feature:
- YSYX_220066_MEM_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When count == TIMEOUT_CYCLES-1 with no ack: deassert req, set sticky tmo=1, go to HOLD (if block) or IDLE.
  - tmo ORs into error for that instruction and clears on the next capture.
- Macro undefined: no counter; WAIT persists until ack.

Decomposition:
- Package ysyx_220066_mem_pkg:
  - MemOp localparams (MEMOP_LB … MEMOP_LWU).
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, HOLD=2'd2).
  - Size-mask constants.
- Sub-module ysyx_220066_lsu_align: combinational misalignment check, wdata/wmask shift, load shift and extension. Instantiated once.

Test Plan:
- Zero-wait lb:
  - Stimulus: addr 0x80000003, MemOp 000, rdata 0x00000000_80FF0000, ack in the same cycle.
  - Required: wb_data=0xFFFFFFFF_FFFFFF80, busy never 1, valid 1 the cycle after capture.
- sd with 3-cycle ack latency:
  - Stimulus: addr 0x80000008, data 0x1122334455667788.
  - Required: req held 3 cycles, wmask=0xFF, busy=1 until ack, valid=0 during the wait, then 1.
- sh at offset 6:
  - Stimulus: data 0xABCD.
  - Required: wmask=0xC0, wdata[63:48]=0xABCD.
- Misaligned lw:
  - Stimulus: addr 0x80000002.
  - Required: dmem_req never asserted, error=1, valid=1.
- ack while block=1:
  - Stimulus: ld ack arrives with block=1; rdata changes afterwards.
  - Required: state HOLD, no second request, wb_data stays the latched value; block drops → IDLE.
- rst during WAIT:
  - Required: dmem_req=0 immediately, valid=0.
  - Late ack: no state change.
  - With YSYX_220066_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4 and no ack: error=1 after 4 WAIT cycles.
